// File: rtl/ahb_sim_ctrl_slave_if.sv
// Bus bundle for the simulation-control slave: AHB-Lite slave port plus the
// console byte stream that drains the character FIFO.
interface ahb_sim_ctrl_slave_if;
   logic        hsel;
   logic [1:0]  htrans;
   logic [11:0] haddr;
   logic        hwrite;
   logic [31:0] hwdata;
   logic        hready;
   logic        hreadyout;
   logic [1:0]  hresp;
   logic [31:0] hrdata;
   logic        con_valid;
   logic [7:0]  con_data;
   logic        con_ready;

   modport slave (
      input  hsel, htrans, haddr, hwrite, hwdata, hready, con_ready,
      output hreadyout, hresp, hrdata, con_valid, con_data
   );

   modport master (
      output hsel, htrans, haddr, hwrite, hwdata, hready, con_ready,
      input  hreadyout, hresp, hrdata, con_valid, con_data
   );
endinterface

// File: rtl/ahb_sim_ctrl_slave.sv
// End-of-test slave: decodes pass/fail codes, buffers console bytes, exposes
// cycle count/status and stops the test if instructions stop retiring.
module ahb_sim_ctrl_slave #(
   parameter int FIFO_DEPTH  = 16,
   parameter int WDOG_PERIOD = 5000
) (
   input  logic                clk,
   input  logic                rst_b,
   ahb_sim_ctrl_slave_if.slave bus,
   input  logic                retire,
   output logic                sim_done,
   output logic                sim_pass,
   output logic                wdog_expired
);
   localparam int AW      = $clog2(FIFO_DEPTH);
   localparam int WW      = $clog2(WDOG_PERIOD);
   localparam int WLAST_I = WDOG_PERIOD - 1;

   localparam logic [9:0]    A_CYCLE  = 10'h3FC;
   localparam logic [9:0]    A_STATUS = 10'h3FD;
   localparam logic [9:0]    A_CTRL   = 10'h3FE;
   localparam logic [AW:0]   FULL_CNT = FIFO_DEPTH[AW:0];
   localparam logic [WW-1:0] WIN_LAST = WLAST_I[WW-1:0];

   typedef enum logic {S_RUN = 1'b0, S_DONE = 1'b1} state_t;

   state_t        r_state, w_state_nxt;
   logic          r_pass, r_wdog;
   logic          r_dp_vld, r_dp_wr;
   logic [9:0]    r_dp_addr;
   logic [31:0]   r_cyc;
   logic [WW-1:0] r_win;
   logic [15:0]   r_ret;
   logic [7:0]    r_mem [FIFO_DEPTH];
   logic [AW-1:0] r_wr_ptr, r_rd_ptr;
   logic [AW:0]   r_count;

   logic w_accept, w_ctrl_wr, w_is_pass, w_is_fail, w_code, w_con_req;
   logic w_full, w_pop, w_push, w_win_end, w_expire;
   logic [7:0] w_cnt8;
   logic w_unused;

   assign w_unused  = &{1'b0, bus.haddr[1:0], bus.htrans[0]};
   assign w_accept  = bus.hsel & bus.hready & bus.htrans[1];
   assign w_ctrl_wr = r_dp_vld & r_dp_wr & (r_dp_addr == A_CTRL);
   assign w_is_pass = (bus.hwdata == 32'h0000_0FFF) | (bus.hwdata == 32'hFFFF_0000);
   assign w_is_fail = (bus.hwdata == 32'h0000_0EEE) | (bus.hwdata == 32'hEEEE_0000);
   assign w_code    = w_ctrl_wr & (r_state == S_RUN) & (w_is_pass | w_is_fail);
   assign w_con_req = w_ctrl_wr & (r_state == S_RUN) & ~(w_is_pass | w_is_fail);

   assign w_full = (r_count == FULL_CNT);
   assign w_pop  = bus.con_valid & bus.con_ready;
   // A pop frees the head slot in the same cycle, so a waiting byte can land immediately.
   assign w_push = w_con_req & (~w_full | w_pop);

   assign bus.hreadyout = ~(w_con_req & w_full & ~w_pop);
   assign bus.hresp     = 2'b00;
   assign bus.con_valid = (r_count != '0);
   assign bus.con_data  = r_mem[r_rd_ptr];

   assign sim_done     = (r_state == S_DONE);
   assign sim_pass     = r_pass;
   assign wdog_expired = r_wdog;

   always_comb begin
      w_cnt8         = '0;
      w_cnt8[AW:0]   = r_count;
   end

   always_comb begin
      bus.hrdata = '0;
      if (r_dp_vld && !r_dp_wr) begin
         case (r_dp_addr)
            A_STATUS: bus.hrdata = {16'b0, w_cnt8, 4'b0, r_wdog, w_full, r_pass, sim_done};
            A_CYCLE:  bus.hrdata = r_cyc;
            default:  bus.hrdata = '0;
         endcase
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_win_end   = 1'b0;
      w_expire    = 1'b0;
      case (r_state)
         S_RUN: begin
            w_win_end = (r_win == WIN_LAST);
            // A bus pass/fail code in the final window cycle takes precedence over expiry.
            if (w_code) begin
               w_state_nxt = S_DONE;
            end else if (w_win_end && (r_ret == '0) && !retire) begin
               w_expire    = 1'b1;
               w_state_nxt = S_DONE;
            end
         end
         default: w_state_nxt = S_DONE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         r_state   <= S_RUN;
         r_pass    <= 1'b0;
         r_wdog    <= 1'b0;
         r_dp_vld  <= 1'b0;
         r_dp_wr   <= 1'b0;
         r_dp_addr <= '0;
         r_cyc     <= '0;
         r_win     <= '0;
         r_ret     <= '0;
         r_wr_ptr  <= '0;
         r_rd_ptr  <= '0;
         r_count   <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_code)   r_pass <= w_is_pass;
         if (w_expire) r_wdog <= 1'b1;
         if (bus.hready) begin
            r_dp_vld  <= w_accept;
            r_dp_wr   <= bus.hwrite;
            r_dp_addr <= bus.haddr[11:2];
         end
         if (r_cyc != 32'hFFFF_FFFF) r_cyc <= r_cyc + 1'b1;
         if (r_state == S_RUN) begin
            if (w_win_end) begin
               r_win <= '0;
               r_ret <= '0;
            end else begin
               r_win <= r_win + 1'b1;
               if (retire && (r_ret != 16'hFFFF)) r_ret <= r_ret + 1'b1;
            end
         end
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= bus.hwdata[7:0];
   end
endmodule

// File: tb/tb_ahb_sim_ctrl_slave.sv
// Bench for ahb_sim_ctrl_slave: queue-based reference model compared every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_ahb_sim_ctrl_slave;
   localparam int DEPTH  = 16;
   localparam int PERIOD = 5000;

   logic clk = 1'b0;
   logic rst_b = 1'b1;
   logic retire = 1'b0;
   logic sim_done, sim_pass, wdog_expired;

   ahb_sim_ctrl_slave_if bus();
   assign bus.hready = bus.hreadyout;

   always #5 clk = ~clk;

   ahb_sim_ctrl_slave #(.FIFO_DEPTH(DEPTH), .WDOG_PERIOD(PERIOD)) dut (
      .clk          (clk),
      .rst_b        (rst_b),
      .bus          (bus),
      .retire       (retire),
      .sim_done     (sim_done),
      .sim_pass     (sim_pass),
      .wdog_expired (wdog_expired)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         if (errors <= 40) $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic timeout_fail(string name);
      checks++;
      errors++;
      $display("FAIL %s timed out waiting for hreadyout", name);
   endtask

   // Reference model: console FIFO as a queue, flags, counters, pending data phase.
   logic [7:0]  mq[$];
   bit          m_done, m_pass, m_wdog;
   logic [31:0] m_cyc;
   int          m_win, m_ret;
   bit          m_dp, m_dpw;
   logic [11:0] m_dpa;

   function automatic bit f_ctrl();
      return m_dp && m_dpw && (m_dpa[11:2] == 10'h3FE);
   endfunction

   function automatic bit f_pass_code();
      return (bus.hwdata == 32'h0000_0FFF) || (bus.hwdata == 32'hFFFF_0000);
   endfunction

   function automatic bit f_code();
      return f_pass_code() || (bus.hwdata == 32'h0000_0EEE) || (bus.hwdata == 32'hEEEE_0000);
   endfunction

   function automatic bit f_console();
      return f_ctrl() && !m_done && !f_code();
   endfunction

   function automatic bit f_pop();
      return (mq.size() != 0) && bus.con_ready;
   endfunction

   function automatic bit f_hready();
      return !(f_console() && (mq.size() == DEPTH) && !f_pop());
   endfunction

   function automatic logic [31:0] f_hrdata();
      logic [31:0] v;
      v = 32'h0;
      if (m_dp && !m_dpw) begin
         if (m_dpa[11:2] == 10'h3FD)
            v = {16'b0, 8'(mq.size()), 4'b0, m_wdog, (mq.size() == DEPTH), m_pass, m_done};
         else if (m_dpa[11:2] == 10'h3FC)
            v = m_cyc;
      end
      return v;
   endfunction

   task automatic model_clear();
      mq.delete();
      m_done = 0; m_pass = 0; m_wdog = 0;
      m_cyc = 0; m_win = 0; m_ret = 0;
      m_dp = 0; m_dpw = 0; m_dpa = 0;
   endtask

   task automatic model_step();
      bit pop, con, code, hr, full, pc;
      pop  = f_pop();
      con  = f_console();
      code = f_ctrl() && !m_done && f_code();
      pc   = f_pass_code();
      hr   = f_hready();
      full = (mq.size() == DEPTH);
      if (m_cyc != 32'hFFFF_FFFF) m_cyc = m_cyc + 1;
      if (pop) void'(mq.pop_front());
      if (con && (!full || pop)) mq.push_back(bus.hwdata[7:0]);
      if (!m_done) begin
         if (code) begin
            m_done = 1;
            m_pass = pc;
         end else if (m_win == PERIOD - 1) begin
            if (m_ret == 0 && !retire) begin
               m_wdog = 1; m_done = 1; m_pass = 0;
            end else begin
               m_win = 0; m_ret = 0;
            end
         end else begin
            m_win++;
            if (retire) m_ret++;
         end
      end
      if (hr) begin
         m_dp  = bus.hsel && bus.htrans[1];
         m_dpw = bus.hwrite;
         m_dpa = bus.haddr;
      end
   endtask

   initial begin : scoreboard
      model_clear();
      forever begin
         @(negedge clk);
         if (!rst_b) model_clear();
         chk("hreadyout", bus.hreadyout, f_hready());
         chk("hresp", bus.hresp, 2'b00);
         chk("con_valid", bus.con_valid, mq.size() != 0);
         if (mq.size() != 0) chk("con_data", bus.con_data, mq[0]);
         chk("sim_done", sim_done, m_done);
         chk("sim_pass", sim_pass, m_pass);
         chk("wdog_expired", wdog_expired, m_wdog);
         chk("hrdata", bus.hrdata, f_hrdata());
         if (rst_b) model_step();
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(int n);
      repeat (n) step();
   endtask

   task automatic ahb_write(logic [11:0] a, logic [31:0] d);
      int n;
      n = 0;
      bus.hsel = 1'b1; bus.htrans = 2'b10; bus.haddr = a; bus.hwrite = 1'b1;
      @(negedge clk);
      while (bus.hreadyout !== 1'b1 && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (n >= 300) timeout_fail("write_addr");
      step();
      bus.hsel = 1'b0; bus.htrans = 2'b00; bus.hwrite = 1'b0; bus.hwdata = d;
   endtask

   task automatic ahb_read(logic [11:0] a, output logic [31:0] d);
      int n;
      n = 0;
      bus.hsel = 1'b1; bus.htrans = 2'b10; bus.haddr = a; bus.hwrite = 1'b0;
      @(negedge clk);
      while (bus.hreadyout !== 1'b1 && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (n >= 300) timeout_fail("read_addr");
      step();
      bus.hsel = 1'b0; bus.htrans = 2'b00;
      @(negedge clk);
      d = bus.hrdata;
      step();
   endtask

   task automatic do_reset();
      @(posedge clk);
      #2;
      rst_b = 1'b0;
      bus.hsel = 1'b0; bus.htrans = 2'b00; bus.hwrite = 1'b0; bus.hwdata = 32'h0;
      bus.con_ready = 1'b0; retire = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      rst_b = 1'b1;
   endtask

   initial begin : global_timeout
      #1500000;
      $display("FAIL global_timeout simulation did not complete");
      errors++;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   logic [31:0] rd1, rd2;
   logic [7:0]  seq [17];
   int          got, cyc, last;

   initial begin : stimulus
      bus.hsel = 1'b0; bus.htrans = 2'b00; bus.haddr = 12'h0; bus.hwrite = 1'b0;
      bus.hwdata = 32'h0; bus.con_ready = 1'b0;
      #2 rst_b = 1'b0;
      @(negedge clk);
      chk("rst_hreadyout", bus.hreadyout, 1'b1);
      chk("rst_con_valid", bus.con_valid, 1'b0);
      chk("rst_flags", {sim_done, sim_pass, wdog_expired}, 3'b000);
      chk("rst_hrdata", bus.hrdata, 32'h0);
      @(posedge clk);
      #2 rst_b = 1'b1;

      // Cycle counter: first read one edge after release, reads 37 cycles apart.
      ahb_read(12'hFF0, rd1);
      chk("cycle_first", rd1, 32'd1);
      idle(35);
      ahb_read(12'hFF0, rd2);
      chk("cycle_delta", rd2 - rd1, 32'd37);

      // Console bytes stream out one per cycle.
      bus.con_ready = 1'b1;
      ahb_write(12'hFF8, 32'h0000_0048);
      ahb_write(12'hFF8, 32'h0000_0069);
      @(negedge clk);
      chk("con_first_valid", bus.con_valid, 1'b1);
      chk("con_first_data", bus.con_data, 8'h48);
      step();
      @(negedge clk);
      chk("con_second_data", bus.con_data, 8'h69);
      step();
      @(negedge clk);
      chk("con_empty", bus.con_valid, 1'b0);
      chk("con_not_done", sim_done, 1'b0);
      step();

      // Status with three queued bytes.
      bus.con_ready = 1'b0;
      ahb_write(12'hFF8, 32'h0000_0041);
      ahb_write(12'hFF8, 32'h0000_0042);
      ahb_write(12'hFF8, 32'h0000_0043);
      ahb_read(12'hFF4, rd1);
      chk("status_3q", rd1, 32'h0000_0300);
      bus.con_ready = 1'b1;
      idle(4);
      bus.con_ready = 1'b0;

      // Fill FIFO, then a 17th byte stalls until a pop.
      for (int i = 0; i < 16; i++) ahb_write(12'hFF8, 32'h0000_0A80 + i);
      ahb_read(12'hFF4, rd1);
      chk("status_full", rd1, 32'h0000_1004);
      ahb_write(12'hFF8, 32'h0000_0A90);
      @(negedge clk);
      chk("stall_17", bus.hreadyout, 1'b0);
      step();
      @(negedge clk);
      chk("stall_hold", bus.hreadyout, 1'b0);
      step();
      bus.con_ready = 1'b1;
      @(negedge clk);
      chk("stall_release", bus.hreadyout, 1'b1);
      chk("release_head", bus.con_data, 8'h80);
      got = 0; cyc = 0; last = -1;
      while (got < 17 && cyc < 60) begin
         if (bus.con_valid && bus.con_ready) begin
            seq[got] = bus.con_data;
            got++;
            last = cyc;
         end
         step();
         @(negedge clk);
         cyc++;
      end
      chk("drain_count", got, 17);
      chk("drain_17th_cycle", last, 16);
      for (int i = 0; i < 17; i++) chk("drain_order", seq[i], 8'h80 + i);
      step();
      bus.con_ready = 1'b0;

      // Pass code ends the test; later codes and bytes are ignored.
      ahb_write(12'hFF8, 32'hFFFF_0000);
      @(negedge clk);
      chk("pass_not_yet", sim_done, 1'b0);
      step();
      @(negedge clk);
      chk("pass_done", sim_done, 1'b1);
      chk("pass_pass", sim_pass, 1'b1);
      step();
      ahb_write(12'hFF8, 32'h0000_0EEE);
      ahb_write(12'hFF8, 32'h0000_0055);
      idle(2);
      @(negedge clk);
      chk("after_done_pass", sim_pass, 1'b1);
      chk("after_done_nopush", bus.con_valid, 1'b0);
      step();
      ahb_read(12'hFF4, rd1);
      chk("status_pass", rd1, 32'h0000_0003);
      idle(5200);
      chk("no_wdog_after_done", wdog_expired, 1'b0);

      // Watchdog expiry with no retires.
      do_reset();
      repeat (4999) @(posedge clk);
      #1;
      @(negedge clk);
      chk("wdog_4999", wdog_expired, 1'b0);
      chk("wdog_4999_done", sim_done, 1'b0);
      step();
      @(negedge clk);
      chk("wdog_5000", wdog_expired, 1'b1);
      chk("wdog_5000_done", sim_done, 1'b1);
      chk("wdog_5000_pass", sim_pass, 1'b0);
      step();
      ahb_read(12'hFF4, rd1);
      chk("status_wdog", rd1, 32'h0000_0009);

      // Pass code data phase on the expiring window cycle wins.
      do_reset();
      repeat (4998) @(posedge clk);
      #1;
      ahb_write(12'hFF8, 32'h0000_0FFF);
      step();
      @(negedge clk);
      chk("race_done", sim_done, 1'b1);
      chk("race_pass", sim_pass, 1'b1);
      chk("race_wdog", wdog_expired, 1'b0);
      step();

      // Reset during a stalled console write.
      do_reset();
      for (int i = 0; i < 17; i++) ahb_write(12'hFF8, 32'h0000_0030 + i);
      @(negedge clk);
      chk("stall_pre_reset", bus.hreadyout, 1'b0);
      @(posedge clk);
      #3 rst_b = 1'b0;
      #1;
      chk("mid_rst_hreadyout", bus.hreadyout, 1'b1);
      chk("mid_rst_con_valid", bus.con_valid, 1'b0);
      chk("mid_rst_flags", {sim_done, sim_pass, wdog_expired}, 3'b000);
      @(posedge clk);
      #2 rst_b = 1'b1;

      // Regular retires keep the watchdog quiet; FIFO contents are gone.
      bus.con_ready = 1'b1;
      for (int i = 0; i < 500; i++) begin
         retire = 1'b1;
         step();
         retire = 1'b0;
         idle(99);
      end
      chk("retire_no_wdog", wdog_expired, 1'b0);
      chk("retire_no_done", sim_done, 1'b0);
      chk("fifo_lost", bus.con_valid, 1'b0);

      ahb_write(12'hFF8, 32'hEEEE_0000);
      step();
      @(negedge clk);
      chk("fail_done", sim_done, 1'b1);
      chk("fail_pass", sim_pass, 1'b0);
      chk("fail_wdog", wdog_expired, 1'b0);
      step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
